// File: rtl/vsu_wide.sv
// rtl/vsu_wide.sv - vector store unit: per-lane operand FIFOs, deshuffle to memory order, beat output
// Request word layout on vfu_req_i: {insn_id, vew, vlB} with vlB in the low bits.
module vsu_wide #(
   parameter int unsigned NrLanes       = 4,
   parameter int unsigned InOpBufDepth  = 4,
   parameter int unsigned BeatWords     = 1,
   parameter int unsigned VRFWordWidthB = 8,
   parameter int unsigned VlBWidth      = 16,
   parameter int unsigned InsnIdWidth   = 3,
   parameter int unsigned VfuWidth      = 3,
   parameter logic [VfuWidth-1:0] VfuVsu = VfuWidth'(4),
   localparam int unsigned W     = VRFWordWidthB * 8,
   localparam int unsigned B     = BeatWords * VRFWordWidthB,
   localparam int unsigned ReqW  = InsnIdWidth + 2 + VlBWidth
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          vfu_req_valid_i,
   output logic                          vfu_req_ready_o,
   input  logic [VfuWidth-1:0]           target_vfu_i,
   input  logic [ReqW-1:0]               vfu_req_i,
   input  logic [NrLanes-1:0]            store_op_valid_i,
   output logic [NrLanes-1:0]            store_op_ready_o,
   input  logic [NrLanes*W-1:0]          store_op_i,
   output logic                          store_op_valid_o,
   input  logic                          store_op_gnt_i,
   output logic [BeatWords*W-1:0]        store_op_o,
   output logic [B-1:0]                  store_strb_o,
   output logic                          store_last_o,
   output logic                          done_o,
   output logic [InsnIdWidth-1:0]        done_insn_id_o
);

   localparam int unsigned NrGrp = NrLanes / BeatWords;
   localparam int unsigned GrpW  = (NrGrp > 1) ? $clog2(NrGrp) : 1;
   localparam int unsigned PtrW  = (InOpBufDepth > 1) ? $clog2(InOpBufDepth) : 1;
   localparam int unsigned CntW  = $clog2(InOpBufDepth + 1);
   localparam int unsigned LaneB = NrLanes * VRFWordWidthB;

   typedef enum logic [1:0] {IDLE, STORE, ZERO} state_e;

   state_e                 state_q, state_d;
   logic [VlBWidth-1:0]    vlb_q, vlb_d;
   logic [1:0]             vew_q, vew_d;
   logic [InsnIdWidth-1:0] id_q, id_d;
   logic [GrpW-1:0]        grp_q, grp_d;

   logic [W-1:0]    fifo_q [NrLanes][InOpBufDepth];
   logic [PtrW-1:0] rptr_q [NrLanes];
   logic [PtrW-1:0] wptr_q [NrLanes];
   logic [CntW-1:0] cnt_q  [NrLanes];

   logic [NrLanes-1:0]   push, nonempty;
   logic [NrLanes*W-1:0] head;
   logic [3:0][NrLanes*W-1:0] desh;
   logic                 pop_all, xfer, accept, req_ready;

   always_comb begin
      for (int l = 0; l < NrLanes; l++) begin
         store_op_ready_o[l]  = (cnt_q[l] != CntW'(InOpBufDepth));
         nonempty[l]          = (cnt_q[l] != '0);
         push[l]              = store_op_valid_i[l] && store_op_ready_o[l] && !flush_i;
         head[l*W +: W]       = fifo_q[l][rptr_q[l]];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int l = 0; l < NrLanes; l++) begin
            rptr_q[l] <= '0;
            wptr_q[l] <= '0;
            cnt_q[l]  <= '0;
         end
      end else begin
         for (int l = 0; l < NrLanes; l++) begin
            if (flush_i) begin
               rptr_q[l] <= '0;
               wptr_q[l] <= '0;
               cnt_q[l]  <= '0;
            end else begin
               if (push[l])
                  wptr_q[l] <= (wptr_q[l] == PtrW'(InOpBufDepth - 1)) ? '0 : wptr_q[l] + PtrW'(1);
               if (pop_all)
                  rptr_q[l] <= (rptr_q[l] == PtrW'(InOpBufDepth - 1)) ? '0 : rptr_q[l] + PtrW'(1);
               cnt_q[l] <= cnt_q[l] + CntW'(push[l]) - CntW'(pop_all);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < NrLanes; l++)
         if (push[l]) fifo_q[l][wptr_q[l]] <= store_op_i[l*W +: W];
   end

   // Element e of width 2^v bytes lives in lane e%NrLanes at slot e/NrLanes of that lane's word.
   for (genvar v = 0; v < 4; v++) begin : g_ew
      for (genvar b = 0; b < LaneB; b++) begin : g_byte
         localparam int unsigned S    = 1 << v;
         localparam int unsigned E    = b / S;
         localparam int unsigned Src  = (E % NrLanes) * VRFWordWidthB + (E / NrLanes) * S + (b % S);
         assign desh[v][b*8 +: 8] = head[Src*8 +: 8];
      end
   end

   assign store_op_o   = (state_q == STORE) ? desh[vew_q][grp_q * (BeatWords*W) +: BeatWords*W] : '0;
   assign store_last_o = (state_q == STORE) && (vlb_q <= VlBWidth'(B));
   assign done_insn_id_o = done_o ? id_q : '0;
   assign vfu_req_ready_o = req_ready;

   always_comb begin
      for (int i = 0; i < B; i++)
         store_strb_o[i] = (state_q == STORE) && (VlBWidth'(i) < vlb_q);
   end

   always_comb begin
      state_d          = state_q;
      vlb_d            = vlb_q;
      vew_d            = vew_q;
      id_d             = id_q;
      grp_d            = grp_q;
      req_ready        = 1'b0;
      done_o           = 1'b0;
      store_op_valid_o = 1'b0;
      pop_all          = 1'b0;
      xfer             = 1'b0;
      accept           = 1'b0;
      case (state_q)
         IDLE: req_ready = 1'b1;
         ZERO: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         STORE: begin
            store_op_valid_o = &nonempty;
            xfer             = store_op_valid_o && store_op_gnt_i;
            if (xfer) begin
               vlb_d = (vlb_q > VlBWidth'(B)) ? vlb_q - VlBWidth'(B) : '0;
               if (store_last_o) begin
                  pop_all   = 1'b1;
                  grp_d     = '0;
                  done_o    = 1'b1;
                  req_ready = 1'b1;
                  state_d   = IDLE;
               end else begin
                  pop_all = (grp_q == GrpW'(NrGrp - 1));
                  grp_d   = pop_all ? '0 : grp_q + GrpW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      accept = req_ready && vfu_req_valid_i && (target_vfu_i == VfuVsu);
      if (accept) begin
         vlb_d   = vfu_req_i[VlBWidth-1:0];
         vew_d   = vfu_req_i[VlBWidth +: 2];
         id_d    = vfu_req_i[VlBWidth+2 +: InsnIdWidth];
         grp_d   = '0;
         state_d = (vfu_req_i[VlBWidth-1:0] == '0) ? ZERO : STORE;
      end
      // Flush overrides any beat transfer or request acceptance in the same cycle.
      if (flush_i) begin
         state_d          = IDLE;
         grp_d            = '0;
         pop_all          = 1'b0;
         done_o           = 1'b0;
         req_ready        = 1'b0;
         store_op_valid_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         vlb_q   <= '0;
         vew_q   <= '0;
         id_q    <= '0;
         grp_q   <= '0;
      end else begin
         state_q <= state_d;
         vlb_q   <= vlb_d;
         vew_q   <= vew_d;
         id_q    <= id_d;
         grp_q   <= grp_d;
      end
   end

   push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(|(store_op_valid_i & ~store_op_ready_o)));

endmodule
